// File: rtl/seq_multu.sv
// seq_multu: multi-cycle unsigned shift-add multiplier (MULTU) beside the ALU.
// Revision: 1.0 - initial release.
`default_nettype none

module seq_multu #(
  parameter int         WIDTH     = 32,
  parameter logic [5:0] CTL_MULTU = 6'd25
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       ctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      count_q, count_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               w_accept;
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_upper;
  logic [2*WIDTH-1:0] w_step;

  assign w_accept = start && (ctl == CTL_MULTU);
  assign w_addend = acc_q[0] ? mcand_q : '0;
  // Carry out of the upper add lands in the MSB once the whole value shifts right.
  assign w_upper  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
  assign w_step   = {w_upper, acc_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    count_d = count_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (w_accept) begin
          mcand_d = a;
          acc_d   = {{WIDTH{1'b0}}, b};
          count_d = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d   = w_step;
        count_d = count_q + 1'b1;
        if (count_q == C_LAST) begin
          hi_d    = w_step[2*WIDTH-1:WIDTH];
          lo_d    = w_step[WIDTH-1:0];
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      mcand_q <= '0;
      acc_q   <= '0;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

`default_nettype wire
